cache_controller: RTL and testbench

- Write-back, write-allocate controller for the 8-line direct-mapped single-word cache table.
- Accepts CPU load/store requests and reads the table's tag, valid, dirty and data outputs for the indexed line.
- Answers hits from the table. On a miss it writes back a dirty victim and refills from memory over a req/ack bus.
- Sits between the pipeline MEM stage and the data memory. It is the only writer of the table.

---
 rtl/cache_controller_if.sv | 57 +++++
 rtl/cache_controller.sv | 158 +++++++++++++++
 tb/tb_cache_controller.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_controller_if.sv
// Bundles the CPU request, cache-table and memory-bus signals of the cache controller.
// slave: the controller's view; master: the surrounding pipeline/table/memory view.
interface cache_controller_if #(
   parameter int TAG_W  = 27,
   parameter int IDX_W  = 3,
   parameter int DATA_W = 32
);
   localparam int ADDR_W = TAG_W + IDX_W + 2;

   // CPU side
   logic              cpu_req_i;
   logic              cpu_we_i;
   logic [ADDR_W-1:0] cpu_addr_i;
   logic [DATA_W-1:0] cpu_wdata_i;
   logic [DATA_W-1:0] cpu_rdata_o;
   logic              cpu_ready_o;
   // Cache table side
   logic              tbl_enable_o;
   logic              tbl_dirty_o;
   logic [IDX_W-1:0]  tbl_index_o;
   logic [TAG_W-1:0]  tbl_tag_o;
   logic [DATA_W-1:0] tbl_data_o;
   logic              tbl_valid_i;
   logic              tbl_dirty_i;
   logic [TAG_W-1:0]  tbl_tag_i;
   logic [DATA_W-1:0] tbl_data_i;
   // Memory side
   logic              mem_req_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic [DATA_W-1:0] mem_rdata_i;
   logic              mem_ack_i;
   // Lookup status
   logic              hit_o;
   logic              miss_o;

   modport slave (
      input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
             tbl_valid_i, tbl_dirty_i, tbl_tag_i, tbl_data_i,
             mem_rdata_i, mem_ack_i,
      output cpu_rdata_o, cpu_ready_o,
             tbl_enable_o, tbl_dirty_o, tbl_index_o, tbl_tag_o, tbl_data_o,
             mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
             hit_o, miss_o
   );

   modport master (
      output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
             tbl_valid_i, tbl_dirty_i, tbl_tag_i, tbl_data_i,
             mem_rdata_i, mem_ack_i,
      input  cpu_rdata_o, cpu_ready_o,
             tbl_enable_o, tbl_dirty_o, tbl_index_o, tbl_tag_o, tbl_data_o,
             mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
             hit_o, miss_o
   );
endinterface

// File: rtl/cache_controller.sv
// Write-back, write-allocate controller for an 8-line direct-mapped single-word cache table.
// Hits are served from the table; misses write back a dirty victim and refill over a req/ack bus.
module cache_controller #(
   parameter int TAG_W  = 27,
   parameter int IDX_W  = 3,
   parameter int DATA_W = 32
) (
   input logic                clk_i,
   input logic                rst_ni,
   cache_controller_if.slave  bus
);
   localparam int ADDR_W = TAG_W + IDX_W + 2;
   localparam int LINE_W = TAG_W + IDX_W;   // word address: {tag, index}

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_COMPARE   = 3'd1;
   localparam logic [2:0] S_WRITEBACK = 3'd2;
   localparam logic [2:0] S_ALLOCATE  = 3'd3;
   localparam logic [2:0] S_REFILL    = 3'd4;
   localparam logic [2:0] S_DONE      = 3'd5;

   logic [2:0]        state_q, state_d;
   logic [LINE_W-1:0] line_q, line_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [DATA_W-1:0] fetch_q, fetch_d;
   logic [ADDR_W-1:0] victim_addr_q, victim_addr_d;
   logic [DATA_W-1:0] victim_data_q, victim_data_d;

   logic [TAG_W-1:0]  lat_tag;
   logic [IDX_W-1:0]  lat_idx;
   logic              hit;

   assign lat_tag = line_q[LINE_W-1:IDX_W];
   assign lat_idx = line_q[IDX_W-1:0];
   assign hit     = bus.tbl_valid_i && (bus.tbl_tag_i == lat_tag);

   // Next state and request/victim/fetch latches.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      state_d       = state_q;
      line_d        = line_q;
      we_d          = we_q;
      wdata_d       = wdata_q;
      rdata_d       = rdata_q;
      fetch_d       = fetch_q;
      victim_addr_d = victim_addr_q;
      victim_data_d = victim_data_q;
      case (state_q)
         S_IDLE: begin
            if (bus.cpu_req_i) begin
               line_d  = bus.cpu_addr_i[ADDR_W-1:2];
               we_d    = bus.cpu_we_i;
               wdata_d = bus.cpu_wdata_i;
               rdata_d = '0;   // stores complete with zero read data
               state_d = S_COMPARE;
            end
         end
         S_COMPARE: begin
            if (hit) begin
               if (!we_q) rdata_d = bus.tbl_data_i;
               state_d = S_DONE;
            end else if (bus.tbl_valid_i && bus.tbl_dirty_i) begin
               victim_addr_d = {bus.tbl_tag_i, lat_idx, 2'b00};
               victim_data_d = bus.tbl_data_i;
               state_d       = S_WRITEBACK;
            end else begin
               state_d = S_ALLOCATE;
            end
         end
         S_WRITEBACK: if (bus.mem_ack_i) state_d = S_ALLOCATE;
         S_ALLOCATE: begin
            if (bus.mem_ack_i) begin
               fetch_d = bus.mem_rdata_i;
               state_d = S_REFILL;
            end
         end
         S_REFILL: begin
            if (!we_q) rdata_d = fetch_q;
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode: table write strobe, memory bus and CPU handshake per state.
   always_comb begin
      bus.cpu_rdata_o  = rdata_q;
      bus.cpu_ready_o  = 1'b0;
      bus.tbl_enable_o = 1'b0;
      bus.tbl_dirty_o  = 1'b0;
      bus.tbl_index_o  = (state_q == S_IDLE) ? bus.cpu_addr_i[IDX_W+1:2] : lat_idx;
      bus.tbl_tag_o    = '0;
      bus.tbl_data_o   = '0;
      bus.mem_req_o    = 1'b0;
      bus.mem_we_o     = 1'b0;
      bus.mem_addr_o   = '0;
      bus.mem_wdata_o  = '0;
      bus.hit_o        = 1'b0;
      bus.miss_o       = 1'b0;
      case (state_q)
         S_COMPARE: begin
            bus.hit_o  = hit;
            bus.miss_o = !hit;
            if (hit && we_q) begin
               bus.tbl_enable_o = 1'b1;
               bus.tbl_tag_o    = lat_tag;
               bus.tbl_data_o   = wdata_q;
               bus.tbl_dirty_o  = 1'b1;
            end
         end
         S_WRITEBACK: begin
            bus.mem_req_o   = 1'b1;
            bus.mem_we_o    = 1'b1;
            bus.mem_addr_o  = victim_addr_q;
            bus.mem_wdata_o = victim_data_q;
         end
         S_ALLOCATE: begin
            bus.mem_req_o  = 1'b1;
            bus.mem_addr_o = {line_q, 2'b00};
         end
         S_REFILL: begin
            bus.tbl_enable_o = 1'b1;
            bus.tbl_tag_o    = lat_tag;
            bus.tbl_data_o   = we_q ? wdata_q : fetch_q;
            bus.tbl_dirty_o  = we_q;
         end
         S_DONE:  bus.cpu_ready_o = 1'b1;
         default: ;
      endcase
   end

   // State and latch registers; reset returns to IDLE with everything cleared.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!rst_ni) begin
         state_q       <= S_IDLE;
         line_q        <= '0;
         we_q          <= 1'b0;
         wdata_q       <= '0;
         rdata_q       <= '0;
         fetch_q       <= '0;
         victim_addr_q <= '0;
         victim_data_q <= '0;
      end else begin
         state_q       <= state_d;
         line_q        <= line_d;
         we_q          <= we_d;
         wdata_q       <= wdata_d;
         rdata_q       <= rdata_d;
         fetch_q       <= fetch_d;
         victim_addr_q <= victim_addr_d;
         victim_data_q <= victim_data_d;
      end
   end
endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: directed scenarios plus random traffic
// against a line/memory-level reference model of a write-back, write-allocate cache.
module tb_cache_controller;
   logic clk_i  = 1'b0;
   logic rst_ni = 1'b0;

   cache_controller_if bus ();

   cache_controller dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   always #5 clk_i = ~clk_i;

   // ---------------- environment: the cache table (sticky dirty flags) ----------------
   logic        t_valid [8] = '{default: 1'b0};
   logic        t_dirty [8] = '{default: 1'b0};
   logic [26:0] t_tag   [8] = '{default: '0};
   logic [31:0] t_data  [8] = '{default: '0};

   assign bus.tbl_valid_i = t_valid[bus.tbl_index_o];
   assign bus.tbl_dirty_i = t_dirty[bus.tbl_index_o];
   assign bus.tbl_tag_i   = t_tag[bus.tbl_index_o];
   assign bus.tbl_data_i  = t_data[bus.tbl_index_o];

   // Table write port.
   always @(posedge clk_i) begin
      if (bus.tbl_enable_o) begin
         t_valid[bus.tbl_index_o] <= 1'b1;
         t_tag[bus.tbl_index_o]   <= bus.tbl_tag_o;
         t_data[bus.tbl_index_o]  <= bus.tbl_data_o;
         t_dirty[bus.tbl_index_o] <= t_dirty[bus.tbl_index_o] | bus.tbl_dirty_o;
      end
   end

   // ---------------- environment memory and reference model ----------------
   logic [31:0] env_mem [logic [31:0]];
   logic [31:0] g_mem   [logic [31:0]];
   logic        g_valid [8];
   logic        g_dirty [8];
   logic [26:0] g_tag   [8];
   logic [31:0] g_data  [8];

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } op_t;

   op_t exp_ops [$];
   op_t cur;
   bit  op_active;
   int  op_cnt;
   int  op_dly;
   bit  b2b;
   int  n_assert = 0;
   int  n_fail   = 0;

   function automatic logic [31:0] mem_init(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [31:0] env_read(input logic [31:0] a);
      return env_mem.exists(a) ? env_mem[a] : mem_init(a);
   endfunction

   function automatic logic [31:0] g_read(input logic [31:0] a);
      return g_mem.exists(a) ? g_mem[a] : mem_init(a);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One CPU transaction: predict from the reference model, then watch the DUT cycle by cycle.
   task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int dly_wb, input int dly_al, input bit hold);
      logic [2:0]  idx;
      logic [26:0] tag;
      logic [31:0] fetched, exp_rdata, exp_tdata;
      bit          hit, wb, done, exp_en;
      int          exp_ready;

      addr = {addr[31:2], 2'b00};
      idx  = addr[4:2];
      tag  = addr[31:5];
      hit  = g_valid[idx] && (g_tag[idx] == tag);
      wb   = !hit && g_valid[idx] && g_dirty[idx];
      exp_ops.delete();
      fetched = '0;
      if (wb) begin
         exp_ops.push_back('{we: 1'b1, addr: {g_tag[idx], idx, 2'b00}, wdata: g_data[idx]});
         g_mem[{g_tag[idx], idx, 2'b00}] = g_data[idx];
      end
      if (!hit) begin
         exp_ops.push_back('{we: 1'b0, addr: addr, wdata: 32'h0});
         fetched = g_read(addr);
      end
      exp_rdata = we ? 32'h0 : (hit ? g_data[idx] : fetched);
      exp_tdata = we ? wdata : fetched;
      exp_ready = hit ? 2 : 3 + (wb ? dly_wb + 1 : 0) + dly_al + 1;
      if (hit && we) begin
         g_data[idx]  = wdata;
         g_dirty[idx] = 1'b1;
      end else if (!hit) begin
         g_valid[idx] = 1'b1;
         g_tag[idx]   = tag;
         g_data[idx]  = exp_tdata;
         g_dirty[idx] = g_dirty[idx] | we;
      end

      bus.cpu_req_i   = 1'b1;
      bus.cpu_we_i    = we;
      bus.cpu_addr_i  = addr;
      bus.cpu_wdata_i = wdata;
      if (b2b) begin
         @(negedge clk_i);
         check("ready_single_cycle", {31'b0, bus.cpu_ready_o}, 32'd0);
      end
      @(posedge clk_i);   // request sampled in IDLE here

      op_active = 1'b0;
      op_cnt    = 0;
      done      = 1'b0;
      for (int cyc = 1; cyc <= 80 && !done; cyc++) begin
         @(negedge clk_i);
         bus.mem_ack_i   = 1'b0;
         bus.mem_rdata_i = $urandom;
         if (cyc == 1) begin
            check("hit_pulse", {31'b0, bus.hit_o}, {31'b0, hit});
            check("miss_pulse", {31'b0, bus.miss_o}, {31'b0, !hit});
         end
         if (cyc == 2) check("lookup_pulse_len", {31'b0, bus.hit_o | bus.miss_o}, 32'd0);

         exp_en = (hit && we && cyc == 1) || (!hit && cyc == exp_ready - 1);
         check("tbl_enable", {31'b0, bus.tbl_enable_o}, {31'b0, exp_en});
         if (exp_en && bus.tbl_enable_o) begin
            check("tbl_index", {29'b0, bus.tbl_index_o}, {29'b0, idx});
            check("tbl_tag", {5'b0, bus.tbl_tag_o}, {5'b0, tag});
            check("tbl_data", bus.tbl_data_o, exp_tdata);
            check("tbl_dirty", {31'b0, bus.tbl_dirty_o}, {31'b0, we});
         end

         if (bus.mem_req_o) begin
            if (!op_active) begin
               if (exp_ops.size() == 0) begin
                  check("unexpected_mem_req", {31'b0, bus.mem_req_o}, 32'd0);
               end else begin
                  cur = exp_ops.pop_front();
                  check("mem_we", {31'b0, bus.mem_we_o}, {31'b0, cur.we});
                  check("mem_addr", bus.mem_addr_o, cur.addr);
                  if (cur.we) check("mem_wdata", bus.mem_wdata_o, cur.wdata);
                  op_active = 1'b1;
                  op_cnt    = 0;
                  op_dly    = cur.we ? dly_wb : dly_al;
               end
            end else begin
               check("mem_hold_addr", bus.mem_addr_o, cur.addr);
               check("mem_hold_we", {31'b0, bus.mem_we_o}, {31'b0, cur.we});
            end
            if (op_active) begin
               op_cnt++;
               if (op_cnt == op_dly + 1) begin
                  bus.mem_ack_i = 1'b1;
                  if (cur.we) env_mem[cur.addr] = bus.mem_wdata_o;
                  else        bus.mem_rdata_i   = env_read(cur.addr);
                  op_active = 1'b0;
               end
            end
         end else begin
            check("mem_bus_idle", bus.mem_addr_o | bus.mem_wdata_o | {31'b0, bus.mem_we_o}, 32'd0);
         end

         if (bus.cpu_ready_o || cyc == exp_ready) begin
            check("ready_cycle", cyc, exp_ready);
            check("ready_level", {31'b0, bus.cpu_ready_o}, 32'd1);
            check("cpu_rdata", bus.cpu_rdata_o, exp_rdata);
            done = 1'b1;
         end
      end
      check("txn_completed", {31'b0, done}, 32'd1);
      check("mem_ops_left", exp_ops.size(), 32'd0);

      if (hold) begin
         b2b = 1'b1;
      end else begin
         bus.cpu_req_i = 1'b0;
         b2b = 1'b0;
         @(negedge clk_i);
      end
   endtask

   initial begin
      bit found;
      foreach (g_valid[i]) begin
         g_valid[i] = 1'b0;
         g_dirty[i] = 1'b0;
         g_tag[i]   = '0;
         g_data[i]  = '0;
      end
      b2b             = 1'b0;
      bus.cpu_req_i   = 1'b0;
      bus.cpu_we_i    = 1'b0;
      bus.cpu_addr_i  = '0;
      bus.cpu_wdata_i = '0;
      bus.mem_ack_i   = 1'b0;
      bus.mem_rdata_i = '0;
      env_mem[32'h40] = 32'hDEAD_BEEF;
      g_mem[32'h40]   = 32'hDEAD_BEEF;

      // Reset state
      #1;
      check("rst_ready", {31'b0, bus.cpu_ready_o}, 32'd0);
      check("rst_rdata", bus.cpu_rdata_o, 32'd0);
      check("rst_mem_req", {31'b0, bus.mem_req_o}, 32'd0);
      check("rst_mem_addr", bus.mem_addr_o, 32'd0);
      check("rst_tbl_enable", {31'b0, bus.tbl_enable_o}, 32'd0);
      check("rst_hit_miss", {30'b0, bus.hit_o, bus.miss_o}, 32'd0);
      @(negedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);

      // 1: cold load miss, fetch returns DEADBEEF
      do_txn(1'b0, 32'h0000_0040, 32'h0, 0, 3, 1'b0);
      check("cold_load_table", t_data[0], 32'hDEAD_BEEF);
      // 2: repeat load hits
      do_txn(1'b0, 32'h0000_0040, 32'h0, 0, 0, 1'b0);
      // 3: store hit, then conflicting load forces writeback of 0x12345678
      do_txn(1'b1, 32'h0000_0040, 32'h1234_5678, 0, 0, 1'b0);
      do_txn(1'b0, 32'h0000_0060, 32'h0, 1, 2, 1'b0);
      check("writeback_data", env_read(32'h40), 32'h1234_5678);
      // 4: store miss to an invalid line
      do_txn(1'b1, 32'h0000_0084, 32'hCAFE_F00D, 0, 0, 1'b0);

      // 5: reset while ALLOCATE holds mem_req_o
      bus.cpu_req_i  = 1'b1;
      bus.cpu_we_i   = 1'b0;
      bus.cpu_addr_i = 32'h0000_0048;
      found = 1'b0;
      for (int k = 0; k < 12 && !found; k++) begin
         @(negedge clk_i);
         if (bus.mem_req_o && !bus.mem_we_o) found = 1'b1;
      end
      check("reached_allocate", {31'b0, found}, 32'd1);
      #2 rst_ni = 1'b0;
      #1;
      check("mid_rst_mem_req", {31'b0, bus.mem_req_o}, 32'd0);
      check("mid_rst_ready", {31'b0, bus.cpu_ready_o}, 32'd0);
      check("mid_rst_tbl_enable", {31'b0, bus.tbl_enable_o}, 32'd0);
      bus.cpu_req_i = 1'b0;
      @(negedge clk_i);
      rst_ni          = 1'b1;
      bus.mem_ack_i   = 1'b1;
      bus.mem_rdata_i = 32'hBAD0_BAD0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_i);
         bus.mem_ack_i = 1'b0;
         check("late_ack_tbl_enable", {31'b0, bus.tbl_enable_o}, 32'd0);
         check("late_ack_ready", {31'b0, bus.cpu_ready_o}, 32'd0);
         check("late_ack_mem_req", {31'b0, bus.mem_req_o}, 32'd0);
      end
      check("no_table_write", {31'b0, t_valid[2]}, 32'd0);

      // 6: back-to-back requests with zero-delay acks
      do_txn(1'b0, 32'h0000_0040, 32'h0, 0, 0, 1'b1);
      do_txn(1'b1, 32'h0000_0088, 32'h0BAD_CAFE, 0, 0, 1'b1);
      do_txn(1'b0, 32'h0000_0088, 32'h0, 0, 0, 1'b0);

      // Random traffic over a small address space to force hits, conflicts and evictions
      for (int i = 0; i < 40; i++) begin
         logic [31:0] a;
         a = {25'b0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'b00};
         do_txn(1'($urandom_range(0, 1)), a, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3),
                (i < 39) && ($urandom_range(0, 3) == 0));
      end

      // Final table contents against the reference model
      for (int i = 0; i < 8; i++) begin
         check("final_valid", {31'b0, t_valid[i]}, {31'b0, g_valid[i]});
         if (g_valid[i]) begin
            check("final_tag", {5'b0, t_tag[i]}, {5'b0, g_tag[i]});
            check("final_data", t_data[i], g_data[i]);
            check("final_dirty", {31'b0, t_dirty[i]}, {31'b0, g_dirty[i]});
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
